// File: rtl/bus_region_decoder_pkg.sv
// Shared types and default widths for the registered bus region decoder.
package bus_region_decoder_pkg;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_N_REGIONS = 4;
   localparam int DEF_WAIT_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERR    = 2'd2
   } state_t;

   // A single region still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_region_decoder_if.sv
// Request, region configuration and response signals between the CPU bus and the decoder.
interface bus_region_decoder_if
   import bus_region_decoder_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int N_REGIONS = DEF_N_REGIONS,
   parameter int WAIT_W    = DEF_WAIT_W
) ();
   localparam int IDX_W = idx_width(N_REGIONS);

   logic                          en;
   logic                          req;
   logic                          we;
   logic [ADDR_W-1:0]             addr;
   logic [N_REGIONS-1:0]          region_en;
   logic [N_REGIONS*ADDR_W-1:0]   region_base;
   logic [N_REGIONS*ADDR_W-1:0]   region_mask;
   logic [N_REGIONS*WAIT_W-1:0]   region_wait;
   logic [N_REGIONS-1:0]          cs;
   logic                          we_o;
   logic                          busy;
   logic                          ack;
   logic                          decode_err;
   logic [IDX_W-1:0]              hit_idx;

   modport master (
      output en, req, we, addr, region_en, region_base, region_mask, region_wait,
      input  cs, we_o, busy, ack, decode_err, hit_idx
   );

   modport slave (
      input  en, req, we, addr, region_en, region_base, region_mask, region_wait,
      output cs, we_o, busy, ack, decode_err, hit_idx
   );

endinterface

// File: rtl/bus_region_decoder_match.sv
// Combinational base/mask compare across all regions with lowest-index priority.
module bus_region_decoder_match
   import bus_region_decoder_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int N_REGIONS = DEF_N_REGIONS,
   parameter int IDX_W     = idx_width(DEF_N_REGIONS)
) (
   input  logic [ADDR_W-1:0]           addr,
   input  logic [N_REGIONS-1:0]        region_en,
   input  logic [N_REGIONS*ADDR_W-1:0] region_base,
   input  logic [N_REGIONS*ADDR_W-1:0] region_mask,
   output logic                        hit,
   output logic [IDX_W-1:0]            idx
);

   // Scan from the top index down so the lowest matching region is the last writer.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if (region_en[i] &&
             ((addr & region_mask[i*ADDR_W +: ADDR_W]) ==
              (region_base[i*ADDR_W +: ADDR_W] & region_mask[i*ADDR_W +: ADDR_W]))) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/bus_region_decoder.sv
// Registered region decoder: one-hot chip select held for a per-region wait count, then ack.
module bus_region_decoder
   import bus_region_decoder_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int N_REGIONS = DEF_N_REGIONS,
   parameter int WAIT_W    = DEF_WAIT_W
) (
   input logic                clk,
   input logic                rst_n,
   bus_region_decoder_if.slave bus
);
   localparam int IDX_W = idx_width(N_REGIONS);

   state_t               state_q, state_d;
   logic [WAIT_W-1:0]    cnt_q, cnt_d;
   logic [N_REGIONS-1:0] cs_q, cs_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic                 m_hit;
   logic [IDX_W-1:0]     m_idx;
   logic [WAIT_W-1:0]    sel_wait;

   bus_region_decoder_match #(
      .ADDR_W    (ADDR_W),
      .N_REGIONS (N_REGIONS),
      .IDX_W     (IDX_W)
   ) u_match (
      .addr        (bus.addr),
      .region_en   (bus.region_en),
      .region_base (bus.region_base),
      .region_mask (bus.region_mask),
      .hit         (m_hit),
      .idx         (m_idx)
   );

   assign sel_wait = bus.region_wait[m_idx*WAIT_W +: WAIT_W];

   // Next state and next output values; config is only looked at on the accept edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cs_d    = cs_q;
      we_d    = we_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.en && bus.req) begin
               we_d = bus.we;
               if (m_hit) begin
                  state_d      = ST_ACCESS;
                  cs_d         = '0;
                  cs_d[m_idx]  = 1'b1;
                  idx_d        = m_idx;
                  cnt_d        = sel_wait;
                  ack_d        = (sel_wait == '0);
               end else begin
                  state_d = ST_ERR;
                  cs_d    = '0;
                  idx_d   = '0;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // ack is registered, so raise it on the edge that makes the count reach zero.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
               ack_d = (cnt_q == WAIT_W'(1));
            end else begin
               state_d = ST_IDLE;
               cs_d    = '0;
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cs_d    = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cs_q    <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.cs         = cs_q;
   assign bus.we_o       = we_q;
   assign bus.busy       = busy_q;
   assign bus.ack        = ack_q;
   assign bus.decode_err = err_q;
   assign bus.hit_idx    = idx_q;

endmodule

// File: doc/bus_region_decoder.md
# bus_region_decoder

Parametrised, registered successor to the combinational address decoder: it maps a bus request address onto one of N_REGIONS base/mask regions, drives a one-hot chip select for a programmable number of wait states, and returns a single-cycle acknowledge. It sits between the CPU bus master and the RAM, ROM and I/O slaves of the 8-bit computer. It also flags accesses that hit no region.

## Interface
- ADDR_W, 8, address width
- N_REGIONS, 4, number of decode regions / chip selects
- WAIT_W, 3, width of per-region wait-state count
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global decode enable; requests ignored while low
- req  in  1  single-cycle request strobe; sampled only when busy=0
- we  in  1  write (1) / read (0) qualifier of req
- addr  in  ADDR_W  request address
- region_en  in  N_REGIONS  per-region enable
- region_base  in  N_REGIONS*ADDR_W  flattened bases, region i at [i*ADDR_W +: ADDR_W]
- region_mask  in  N_REGIONS*ADDR_W  flattened compare masks, same packing
- region_wait  in  N_REGIONS*WAIT_W  flattened wait-state counts, same packing
- cs  out  N_REGIONS  registered one-hot chip select
- we_o  out  1  latched we for the active access
- busy  out  1  high whenever state != IDLE
- ack  out  1  one-cycle completion pulse
- decode_err  out  1  one-cycle pulse with ack on a miss
- hit_idx  out  $clog2(N_REGIONS)  latched index of the active region; 0 on miss

## Operation
- States: IDLE, ACCESS, ERR.
- Accept: in IDLE with en=1 and req=1.
- Hit rule: region i hits iff region_en[i] && ((addr & mask_i) == (base_i & mask_i)).
- Overlapping hits: the lowest index wins.
- On accept with a hit on region k:
  - go to ACCESS.
  - cs[k]=1; hit_idx=k; we_o=we.
  - counter loaded with region_wait_k.
- In ACCESS:
  - counter > 0: decrement.
  - counter == 0: ack=1 this cycle, then go to IDLE next edge with cs=0.
- On accept with no hit:
  - go to ERR for exactly one cycle: ack=1, decode_err=1, cs=0, hit_idx=0.
  - then go to IDLE.
- Configuration inputs (base, mask, wait, region_en) are used only at the accept edge. Changes during ACCESS do not affect the access in flight.
- en going low during ACCESS does not abort the access.
- req while busy=1 is ignored and not queued.
- All-zero mask matches every address. N_REGIONS=1 gives a 1-bit hit_idx.

## Timing
- Reset (async, rst_n=0): state=IDLE, cs=0, we_o=0, busy=0, ack=0, decode_err=0, hit_idx=0, counter=0. Takes effect mid-access with no ack issued.
- Hit with wait W: req sampled at edge 0. cs high and busy high from edge 0 to edge W+1, i.e. W+1 cycles. ack is high in the last of those cycles. busy is low from edge W+1.
- Earliest next accept is the cycle after ack, so back-to-back zero-wait accesses have a 2-cycle period.
- Miss: ack, decode_err and busy are high for 1 cycle after the accept edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package bus_region_decoder_pkg holds:
  - state enum (IDLE, ACCESS, ERR)
  - default width localparams
- Sub-module region_match holds the combinational mask compare and lowest-index priority encoder. Its outputs are hit and idx.
- Top level holds the FSM, the wait counter and the output registers.

## Test plan
All scenarios use defaults. Region setup:
- r0: base 0x00, mask 0x80, wait 0 (RAM)
- r1: base 0x80, mask 0xC0, wait 2 (ROM)
- r2: base 0xF0, mask 0xF0, wait 1 (I/O)
- r3: disabled

Scenarios:
- Read 0x3A: cs=0001 for 1 cycle with ack in that cycle, hit_idx=0; busy low next cycle.
- Read 0x85: cs=0010 for 3 cycles, ack in the 3rd cycle, hit_idx=1.
- Write 0xF4: r2 hits (r1 mask misses), cs=0100 for 2 cycles, we_o=1, hit_idx=2.
- Miss and priority:
  - Disable r2, read 0xF4: ack=1 and decode_err=1 for 1 cycle, cs=0000.
  - Enable r3 with base 0x00, mask 0x00, read 0x10: r0 wins, cs=0001.
- Request while busy and config change:
  - Strobe req during the r1 access: ignored.
  - Change region_wait1 to 7 mid-access: the access still ends after 3 cycles.
  - en=0 with req=1: no activity.
- Reset mid-access: drop rst_n in the 2nd cycle of an r1 access. All outputs go to 0 immediately and no ack is issued. A new read of 0x3A after release completes normally.
